// File: rtl/branch_pattern_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_pattern_table
// Purpose  : 2**IDX_W-entry table of CTR_W-bit saturating counters used for
//            dynamic branch prediction. Registered one-cycle lookup, update
//            bypass for same-cycle same-index read, optional gshare indexing
//            enabled by defining the macro BPT_GSHARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_pattern_table #(
    parameter int IDX_W = 5,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             rd_valid,
    input  logic [IDX_W-1:0] rd_addr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [IDX_W-1:0] pred_idx
);

    localparam int             c_DEPTH   = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] c_CTR_MAX = {CTR_W{1'b1}};
    // Weakly not-taken: the value just below the taken threshold.
    localparam logic [CTR_W-1:0] c_CTR_RST = CTR_W'((64'd1 << (CTR_W - 1)) - 64'd1);

    logic [CTR_W-1:0] r_table [c_DEPTH];
    logic             r_pred_valid;
    logic [CTR_W-1:0] r_pred_ctr;
    logic [IDX_W-1:0] r_pred_idx;

    logic [IDX_W-1:0] w_idx;
    logic [CTR_W-1:0] w_upd_cur;
    logic [CTR_W-1:0] w_upd_next;
    logic             w_upd_fire;
    logic [CTR_W-1:0] w_rd_ctr;

    assign w_upd_fire = en && upd_valid;

`ifdef BPT_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // Lookups hash the address with the pre-shift history.
    assign w_idx = rd_addr ^ r_ghr;

    generate
        if (IDX_W == 1) begin : g_ghr_one
            // Single-bit history simply remembers the last resolved outcome.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n)
                    r_ghr <= '0;
                else if (w_upd_fire)
                    r_ghr <= upd_taken;
            end
        end else begin : g_ghr_shift
            // Shift each resolved outcome into the history LSB.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n)
                    r_ghr <= '0;
                else if (w_upd_fire)
                    r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
            end
        end
    endgenerate
`else
    assign w_idx = rd_addr;
`endif

    assign w_upd_cur = r_table[upd_idx];

    // Saturating increment/decrement of the entry being trained.
    always_comb begin
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != c_CTR_MAX)
                w_upd_next = w_upd_cur + CTR_W'(1);
        end else begin
            if (w_upd_cur != '0)
                w_upd_next = w_upd_cur - CTR_W'(1);
        end
    end

    // Bypass: a lookup hitting the entry being updated sees the new value.
    always_comb begin
        w_rd_ctr = r_table[w_idx];
        if (w_upd_fire && (upd_idx == w_idx))
            w_rd_ctr = w_upd_next;
    end

    // Counter table storage; one entry written per enabled update.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_table[i] <= c_CTR_RST;
        end else if (w_upd_fire) begin
            r_table[upd_idx] <= w_upd_next;
        end
    end

    // Registered prediction; ctr/idx hold when no lookup is requested.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_ctr   <= '0;
            r_pred_idx   <= '0;
        end else if (en) begin
            r_pred_valid <= rd_valid;
            if (rd_valid) begin
                r_pred_ctr <= w_rd_ctr;
                r_pred_idx <= w_idx;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_ctr   = r_pred_ctr;
    assign pred_idx   = r_pred_idx;
    assign pred_taken = r_pred_ctr[CTR_W-1];

endmodule
`default_nettype wire

// File: tb/tb_branch_pattern_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pattern_table
// Purpose  : Directed bench for branch_pattern_table with a table-of-integers
//            reference model and a per-cycle output compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pattern_table;

    localparam int IDX_W = 5;
    localparam int CTR_W = 2;
    localparam int DEPTH = 32;

    logic             clk       = 1'b0;
    logic             arst_n    = 1'b1;
    logic             en        = 1'b0;
    logic             rd_valid  = 1'b0;
    logic [IDX_W-1:0] rd_addr   = '0;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx   = '0;
    logic             upd_taken = 1'b0;
    logic             pred_valid;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic [IDX_W-1:0] pred_idx;

    branch_pattern_table #(.IDX_W(IDX_W), .CTR_W(CTR_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .en         (en),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ctr   (pred_ctr),
        .pred_idx   (pred_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_tbl [DEPTH];
    int m_ghr;
    int exp_valid;
    int exp_ctr;
    int exp_idx;
    bit chk_en = 1'b0;

`ifdef BPT_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model: counters as plain integers, history as an integer shift register.
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
        m_ghr     = 0;
        exp_valid = 0;
        exp_ctr   = 0;
        exp_idx   = 0;
    endtask

    task automatic model_step(input bit e, input bit rv, input int ra,
                              input bit uv, input int ui, input bit ut);
        int idx;
        if (!e) return;
        idx = GSHARE ? (ra ^ m_ghr) : ra;
        if (uv) begin
            if (ut) m_tbl[ui] = (m_tbl[ui] + 1 > 3) ? 3 : m_tbl[ui] + 1;
            else    m_tbl[ui] = (m_tbl[ui] - 1 < 0) ? 0 : m_tbl[ui] - 1;
            if (GSHARE) m_ghr = ((m_ghr * 2) + int'(ut)) % DEPTH;
        end
        if (rv) begin
            exp_valid = 1;
            exp_idx   = idx;
            exp_ctr   = m_tbl[idx];
        end else begin
            exp_valid = 0;
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", int'(pred_valid), exp_valid);
            check("cyc_ctr",   int'(pred_ctr),   exp_ctr);
            check("cyc_taken", int'(pred_taken), (exp_ctr >= 2) ? 1 : 0);
            check("cyc_idx",   int'(pred_idx),   exp_idx);
        end
    end

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input bit e, input bit rv, input int ra,
                        input bit uv, input int ui, input bit ut);
        en        = e;
        rd_valid  = rv;
        rd_addr   = IDX_W'(ra);
        upd_valid = uv;
        upd_idx   = IDX_W'(ui);
        upd_taken = ut;
        @(posedge clk);
        #1;
        model_step(e, rv, ra, uv, ui, ut);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid low-phase; outputs must clear at once.
    task automatic reset_dut();
        #2;
        arst_n = 1'b0;
        model_reset();
        en = 1'b0; rd_valid = 1'b0; upd_valid = 1'b0;
        #1;
        check("rst_valid", int'(pred_valid), 0);
        check("rst_ctr",   int'(pred_ctr),   0);
        check("rst_taken", int'(pred_taken), 0);
        check("rst_idx",   int'(pred_idx),   0);
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        reset_dut();
        chk_en = 1'b1;

        // Fresh table: every entry weakly not-taken.
        for (int a = 0; a < DEPTH; a++) begin
            step(1, 1, a, 0, 0, 0);
            check("t1_ctr", int'(pred_ctr), 1);
        end
        check("t1_valid", int'(pred_valid), 1);
        check("t1_taken", int'(pred_taken), 0);

        // Train idx 3 up to saturation, then down to saturation.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 3, 1);
        step(1, 1, 3, 0, 0, 0);
`ifndef BPT_GSHARE_EN
        check("t2_up_ctr",   int'(pred_ctr),   3);
        check("t2_up_taken", int'(pred_taken), 1);
`endif
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 3, 0);
        step(1, 1, 3, 0, 0, 0);
`ifndef BPT_GSHARE_EN
        check("t2_dn_ctr",   int'(pred_ctr),   0);
        check("t2_dn_taken", int'(pred_taken), 0);
`endif

        // Disabled cycle: requests dropped, outputs frozen.
        step(0, 1, 3, 1, 3, 1);
        check("t4_hold_valid", int'(pred_valid), 1);
`ifndef BPT_GSHARE_EN
        check("t4_hold_idx", int'(pred_idx), 3);
`endif
        step(1, 0, 0, 0, 0, 0);
        check("t4_novalid", int'(pred_valid), 0);
        step(1, 1, 3, 0, 0, 0);
`ifndef BPT_GSHARE_EN
        check("t4_ctr", int'(pred_ctr), 0);
`endif

        // Same-cycle read/update of one index returns the updated counter.
        reset_dut();
        step(1, 1, 7, 1, 7, 1);
        check("t3_ctr",   int'(pred_ctr),   2);
        check("t3_taken", int'(pred_taken), 1);
        check("t3_idx",   int'(pred_idx),   7);

        // Train idx 5 to strongly taken, then reset mid-operation.
        step(1, 0, 0, 1, 5, 1);
        step(1, 0, 0, 1, 5, 1);
        step(1, 1, 5, 0, 0, 0);
`ifndef BPT_GSHARE_EN
        check("t5_trained", int'(pred_ctr), 3);
`endif
        en = 1'b1; rd_valid = 1'b1; rd_addr = 5; upd_valid = 1'b1; upd_idx = 5; upd_taken = 1'b1;
        reset_dut();
        step(1, 1, 5, 0, 0, 0);
        check("t5_post_rst_ctr", int'(pred_ctr), 1);

        // Mixed traffic including enable gaps and index collisions.
        for (int i = 0; i < 40; i++) begin
            step((i % 9) != 0, (i % 3) != 2, (i * 7) % DEPTH,
                 (i % 4) != 3, ((i % 5) == 0) ? (i * 7) % DEPTH : (i * 5 + 3) % DEPTH,
                 ((i * i) % 3) != 0);
        end

        // History hashing of the lookup index.
        reset_dut();
        step(1, 0, 0, 1, 10, 1);
        step(1, 0, 0, 1, 20, 1);
        step(1, 1, 1, 0, 0, 0);
        check("t6_idx", int'(pred_idx), GSHARE ? 2 : 1);

        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
